// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweeper/checker for small combinational networks
//
// Purpose: on an accepted start, drives every input vector 0..2^N_IN-1 onto the
// network under test in ascending order. Each vector is held for SETTLE+1
// cycles, then the network output is sampled and compared against a truth
// table latched at start. Reports the mismatch count, the first failing vector
// and pass/fail.
//
// Parameters:
//   N_IN    number of network inputs (1..8)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   begin a sweep (sampled only in IDLE)
//   expected         in   truth table, bit v = required output for vector v
//   dut_in           out  vector driven to the network (MSB = first input)
//   dut_out          in   network output
//   busy             out  sweep in progress
//   done             out  one-cycle pulse at sweep completion
//   pass             out  last sweep had zero mismatches
//   err_count        out  mismatch count, range 0..2^N_IN
//   first_fail       out  lowest mismatching vector
//   first_fail_valid out  first_fail is meaningful
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_count,
  output logic [N_IN-1:0]         first_fail,
  output logic                    first_fail_valid
);

  localparam int NV = 1 << N_IN;
  localparam logic [3:0]      HOLD_LAST = 4'(SETTLE);
  localparam logic [N_IN:0]   ERR_ONE   = 1;
  localparam logic [N_IN-1:0] VEC_ONE   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NV-1:0]   expected_q, expected_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      hold_q, hold_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ffv_q, ffv_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      expected_q <= '0;
      vec_q      <= '0;
      hold_q     <= '0;
      err_q      <= '0;
      ff_q       <= '0;
      ffv_q      <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      ffv_q      <= ffv_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    err_d      = err_q;
    ff_d       = ff_q;
    ffv_d      = ffv_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_DRIVE;
          expected_d = expected;
          vec_d      = '0;
          hold_d     = '0;
          err_d      = '0;
          ff_d       = '0;
          ffv_d      = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          if (dut_out != expected_q[vec_q]) begin
            err_d = err_q + ERR_ONE;
            if (!ffv_q) begin
              ff_d  = vec_q;
              ffv_d = 1'b1;
            end
          end
          // Terminal test on the all-ones vector so vec never wraps mid-sweep.
          if (&vec_q) begin
            state_d = S_DONE;
            vec_d   = '0;   // dut_in returns to 0 for the DONE cycle
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d  = vec_q + VEC_ONE;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // vec_q is held at 0 outside DRIVE, so dut_in is a plain register output.
  assign dut_in           = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule
